// File: rtl/sreg_pipe_pkg.sv
// Shared types and helpers for the shift-register pipeline controller.
package sreg_pipe_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        FLUSH = 2'd3
    } state_e;

    function automatic int unsigned occ_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sreg_valid_tracker.sv
// Shadow valid bits for a globally-enabled shift pipeline plus an occupancy count.
module sreg_valid_tracker
    import sreg_pipe_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned OCC_W = occ_width(DEPTH)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             push,
    input  logic             pop,
    input  logic             clear,
    output logic [DEPTH-1:0] vld,
    output logic [OCC_W-1:0] occupancy
);

    logic [DEPTH-1:0] vld_q, vld_d;
    logic [OCC_W-1:0] occ_q, occ_d;

    always_comb begin
        vld_d = vld_q;
        occ_d = occ_q;
        if (clear) begin
            vld_d = '0;
            occ_d = '0;
        end else begin
            if (en) begin
                vld_d = {vld_q[DEPTH-2:0], push};
            end
            occ_d = occ_q + OCC_W'(push) - OCC_W'(pop);
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            vld_q <= '0;
            occ_q <= '0;
        end else begin
            vld_q <= vld_d;
            occ_q <= occ_d;
        end
    end

    assign vld       = vld_q;
    assign occupancy = occ_q;

endmodule

// File: rtl/sreg_pipeline_ctrl.sv
// Handshake/sequencing controller wrapped around a single-enable shift-register pipeline.
module sreg_pipeline_ctrl
    import sreg_pipe_pkg::*;
#(
    parameter int unsigned DATA_W = 9,
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned CNT_W  = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         start,
    input  logic                         drain,
    input  logic                         flush,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [DATA_W-1:0]            in_data,
    output logic [DATA_W-1:0]            pipe_a,
    output logic                         pipe_en,
    input  logic [DATA_W-1:0]            pipe_c,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [DATA_W-1:0]            out_data,
    output logic                         busy,
    output logic                         done,
    output logic [occ_width(DEPTH)-1:0]  occupancy,
    output logic [CNT_W-1:0]             accepted
);

    localparam int unsigned OCC_W = occ_width(DEPTH);

    state_e           state_q, state_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] accepted_q, accepted_d;
    logic [DEPTH-1:0] vld;
    logic             stall, accept, xfer, clear;

    assign stall     = vld[DEPTH-1] & ~out_ready;
    assign pipe_en   = ~stall & (state_q != FLUSH);
    assign in_ready  = (state_q == RUN) & pipe_en;
    // The tail stage may still hold a valid bit during FLUSH; it is never presented.
    assign out_valid = vld[DEPTH-1] & (state_q != FLUSH);
    assign accept    = in_valid & in_ready;
    assign xfer      = out_valid & out_ready;
    assign clear     = flush | (state_q == FLUSH);

    assign pipe_a    = in_data;
    assign out_data  = pipe_c;
    assign busy      = (state_q != IDLE) | (|vld);
    assign done      = done_q;
    assign accepted  = accepted_q;

    sreg_valid_tracker #(
        .DEPTH (DEPTH),
        .OCC_W (OCC_W)
    ) u_tracker (
        .clock     (clock),
        .reset     (reset),
        .en        (pipe_en),
        .push      (accept),
        .pop       (xfer),
        .clear     (clear),
        .vld       (vld),
        .occupancy (occupancy)
    );

    always_comb begin
        state_d    = state_q;
        done_d     = 1'b0;
        accepted_d = accepted_q + CNT_W'(accept);
        case (state_q)
            IDLE: begin
                if (flush) begin
                    state_d = FLUSH;
                end else if (drain) begin
                    if (occupancy != '0) state_d = DRAIN;
                    else                 done_d  = 1'b1;
                end else if (start) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (flush)      state_d = FLUSH;
                else if (drain) state_d = DRAIN;
            end
            DRAIN: begin
                // Empty once the last in-flight word leaves on this edge.
                if (flush) begin
                    state_d = FLUSH;
                end else if (occupancy == OCC_W'(xfer)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            FLUSH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            done_q     <= 1'b0;
            accepted_q <= '0;
        end else begin
            state_q    <= state_d;
            done_q     <= done_d;
            accepted_q <= accepted_d;
        end
    end

endmodule

// File: tb/tb_sreg_pipeline_ctrl.sv
// Scoreboard bench: controller paired with a 4-stage, 9-bit enabled shift pipeline.
module tb_sreg_pipeline_ctrl;
    import sreg_pipe_pkg::*;

    localparam int unsigned DATA_W = 9;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = 16;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              start = 1'b0, drain = 1'b0, flush = 1'b0;
    logic              in_valid = 1'b0, out_ready = 1'b0;
    logic [DATA_W-1:0] in_data = '0;
    logic              in_ready, pipe_en, out_valid, busy, done;
    logic [DATA_W-1:0] pipe_a, pipe_c, out_data;
    logic [2:0]        occupancy;
    logic [CNT_W-1:0]  accepted;

    logic [DATA_W-1:0] pst [DEPTH];
    logic [DATA_W-1:0] exp_q [$];
    int total = 0;
    int bad = 0;
    int exp_acc = 0;

    always #5 clock = ~clock;

    sreg_pipeline_ctrl #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .CNT_W  (CNT_W)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .start     (start),
        .drain     (drain),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .pipe_a    (pipe_a),
        .pipe_en   (pipe_en),
        .pipe_c    (pipe_c),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .occupancy (occupancy),
        .accepted  (accepted)
    );

    // Controlled pipeline: no reset, contents go stale across reset.
    always @(posedge clock) begin
        if (pipe_en) pst <= '{pipe_a, pst[0], pst[1], pst[2]};
    end
    assign pipe_c = pst[DEPTH-1];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got=%0d required=%0d", name, act, req);
        end
    endtask

    always @(negedge clock) begin
        if (reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_output: got=%0d required=no word", out_data);
            end else begin
                chk("out_data", out_data, exp_q.pop_front());
            end
        end
    end

    task automatic cyc(input logic v, input logic [DATA_W-1:0] d, input logic ordy,
                       input logic st, input logic dr, input logic fl, input logic exp_ir);
        @(posedge clock);
        #1;
        in_valid = v; in_data = d; out_ready = ordy;
        start = st; drain = dr; flush = fl;
        @(negedge clock);
        chk("in_ready", in_ready, exp_ir);
        if (v && exp_ir) begin
            exp_q.push_back(d);
            exp_acc++;
        end
    endtask

    task automatic drain_wait(input int exp_k);
        bit seen = 1'b0;
        for (int k = 0; k < 20 && !seen; k++) begin
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            if (done) begin
                seen = 1'b1;
                chk("drain_latency", k, exp_k);
                chk("drain_occupancy", occupancy, 0);
                chk("drain_busy", busy, 0);
                chk("drain_state", dut.state_q, IDLE);
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL done_timeout: got=no done pulse required=done within 20 cycles");
        end else begin
            cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("done_pulse_width", done, 0);
        end
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: got=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        #2;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_accepted", accepted, 0);
        chk("rst_done", done, 0);
        @(posedge clock); @(posedge clock); #3;
        reset = 1'b1;

        // Streaming at full rate
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            cyc(1'b1, DATA_W'(i + 1), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
            chk("t1_out_valid", out_valid, (i >= 4) ? 1 : 0);
            chk("t1_occupancy", occupancy, (i < 4) ? i : 4);
        end

        // Backpressure on a full pipeline
        for (int j = 0; j < 3; j++) begin
            cyc(1'b1, 9'd21, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
            if (j == 0) chk("t1_accepted", accepted, 20);
            chk("t2_pipe_en", pipe_en, 0);
            chk("t2_out_valid", out_valid, 1);
            chk("t2_out_data", out_data, 17);
            chk("t2_occupancy", occupancy, 4);
        end
        cyc(1'b1, 9'd21, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b1, 9'd22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        repeat (6) cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t2_empty_occupancy", occupancy, 0);
        chk("t2_accepted", accepted, 22);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        drain_wait(1);

        // Drain with words in flight
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 6; k++) cyc(1'b1, DATA_W'(101 + k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        drain_wait(3);
        chk("t3_accepted", accepted, 28);

        // Flush and drain together: flush wins
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b1, DATA_W'(201 + k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("t4_pre_occupancy", occupancy, 3);
        exp_q.delete();
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_out_valid", out_valid, 0);
        chk("t4_occupancy", occupancy, 0);
        chk("t4_pipe_en", pipe_en, 0);
        chk("t4_done", done, 0);
        chk("t4_accepted", accepted, 32'(16'(exp_acc)));
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        chk("t4_state", dut.state_q, IDLE);
        chk("t4_busy", busy, 0);
        chk("t4_done_after", done, 0);

        // Asynchronous reset mid-stream
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 5; k++) cyc(1'b1, DATA_W'(301 + k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        chk("t5_pre_out_valid", out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        chk("t5_async_out_valid", out_valid, 0);
        chk("t5_async_in_ready", in_ready, 0);
        chk("t5_async_occupancy", occupancy, 0);
        chk("t5_async_busy", busy, 0);
        in_valid = 1'b0;
        exp_q.delete();
        exp_acc = 0;
        @(posedge clock); @(posedge clock); #2;
        reset = 1'b1;
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b1, DATA_W'(401 + k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        drain_wait(3);
        chk("t5_accepted", accepted, 3);

        // Accepted counter wrap
        @(negedge clock);
        force dut.accepted_q = 16'hFFFE;
        #1;
        release dut.accepted_q;
        chk("t6_preload", accepted, 32'hFFFE);
        cyc(1'b0, '0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) cyc(1'b1, DATA_W'(501 + k), 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("t6_wrap", accepted, 1);
        drain_wait(3);
        chk("t6_wrap_hold", accepted, 1);

        chk("queue_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
